// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between NUM_REQ requesters.
// Optional per-requester accept counters are built when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*32-1:0]  req_operand_a,
   input  logic [NUM_REQ*32-1:0]  req_operand_b,
   input  logic [NUM_REQ*4-1:0]   req_select_op,
   output logic [NUM_REQ-1:0]     resp_valid,
   input  logic [NUM_REQ-1:0]     resp_ready,
   output logic [31:0]            resp_data,
   output logic [31:0]            alu_operand_a,
   output logic [31:0]            alu_operand_b,
   output logic [3:0]             alu_select_op,
   input  logic [31:0]            alu_result_in,
   output logic [NUM_REQ*16-1:0]  grant_count
);

   typedef enum logic {IDLE, RESP} state_t;

   state_t           state, state_nx;
   logic [PTR_W-1:0] owner, last_grant, gnt;
   logic             found, owner_rdy, can_accept, accept;

   function automatic int wrap_add(input int base, input int k);
      int r;
      r = base + k;
      return (r >= NUM_REQ) ? r - NUM_REQ : r;
   endfunction

   // Response-ready of the current owner.
   always_comb begin
      owner_rdy = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         if (owner == PTR_W'(i)) owner_rdy = resp_ready[i];
   end

   // Round-robin pick: first valid requester after last_grant.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      for (int k = 1; k <= NUM_REQ; k++)
         for (int i = 0; i < NUM_REQ; i++)
            if (!found && req_valid[i] &&
                i == wrap_add(int'(last_grant), k)) begin
               found = 1'b1;
               gnt   = PTR_W'(i);
            end
   end

   assign can_accept = (state == IDLE) || owner_rdy;
   assign accept     = can_accept && found;

   // Next state, accept strobes, response valid and ALU drive.
   always_comb begin
      state_nx      = state;
      req_ready     = '0;
      resp_valid    = '0;
      alu_operand_a = '0;
      alu_operand_b = '0;
      alu_select_op = '0;
      if (state == RESP)
         for (int i = 0; i < NUM_REQ; i++)
            resp_valid[i] = (owner == PTR_W'(i));
      if (accept) begin
         state_nx = RESP;
         for (int i = 0; i < NUM_REQ; i++)
            if (gnt == PTR_W'(i)) begin
               req_ready[i]  = 1'b1;
               alu_operand_a = req_operand_a[32*i +: 32];
               alu_operand_b = req_operand_b[32*i +: 32];
               alu_select_op = req_select_op[4*i +: 4];
            end
      end else if (state == RESP && owner_rdy) begin
         state_nx = IDLE;
      end
   end

   // State, owner and registered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= '0;
         last_grant <= PTR_W'(NUM_REQ - 1);
         resp_data  <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            resp_data  <= alu_result_in;
            owner      <= gnt;
            last_grant <= gnt;
         end
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [15:0] cnt [NUM_REQ];

   // Saturating per-requester accept counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++)
            if (accept && gnt == PTR_W'(i) && cnt[i] != 16'hFFFF)
               cnt[i] <= cnt[i] + 16'd1;
      end
   end

   // Pack the counters onto the flat port.
   always_comb begin
      grant_count = '0;
      for (int i = 0; i < NUM_REQ; i++)
         grant_count[16*i +: 16] = cnt[i];
   end
`else
   assign grant_count = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and random stimulus against a
// transaction-level arbiter/ALU reference model.
module tb_alu_share_arbiter;

   localparam int N = 2;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*32-1:0] req_operand_a;
   logic [N*32-1:0] req_operand_b;
   logic [N*4-1:0]  req_select_op;
   logic [N-1:0]    resp_valid;
   logic [N-1:0]    resp_ready;
   logic [31:0]     resp_data;
   logic [31:0]     alu_operand_a;
   logic [31:0]     alu_operand_b;
   logic [3:0]      alu_select_op;
   logic [31:0]     alu_result_in;
   logic [N*16-1:0] grant_count;

   int n_vec = 0;
   int n_bad = 0;

   bit          m_busy;
   int          m_owner;
   int          m_last;
   logic [31:0] m_data;
   int          m_cnt [N];
   bit [N-1:0]  pend;

   alu_share_arbiter #(.NUM_REQ(N), .PTR_W(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
      .req_select_op(req_select_op),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data),
      .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
      .alu_select_op(alu_select_op), .alu_result_in(alu_result_in),
      .grant_count(grant_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ALU: signed/unsigned add/sub, default add.
   always_comb begin
      unique case (alu_select_op)
         4'd1:    alu_result_in = alu_operand_a - alu_operand_b;
         4'd2:    alu_result_in = 32'($signed(alu_operand_a) + $signed(alu_operand_b));
         4'd3:    alu_result_in = 32'($signed(alu_operand_a) - $signed(alu_operand_b));
         default: alu_result_in = alu_operand_a + alu_operand_b;
      endcase
   end

   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] s);
      return (s == 4'd1 || s == 4'd3) ? a + (~b + 32'd1) : a + b;
   endfunction

   function automatic bit bit_at(input logic [N-1:0] v, input int i);
      return 1'(v >> i);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] s);
      req_operand_a[32*i +: 32] = a;
      req_operand_b[32*i +: 32] = b;
      req_select_op[4*i +: 4]   = s;
   endtask

   // One clock: check outputs against the model, then advance the model.
   task automatic cycle(input bit do_chk);
      int            g;
      int            idx;
      logic [N-1:0]  one;
      logic [N-1:0]  e_rdy;
      logic [N-1:0]  e_rv;
      logic [31:0]   ea;
      logic [31:0]   eb;
      logic [3:0]    es;
      logic [N*16-1:0] e_gc;
      one = 1;
      #1;
      g = -1;
      if (!m_busy || bit_at(resp_ready, m_owner))
         for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (g < 0 && bit_at(req_valid, idx)) g = idx;
         end
      e_rdy = (g >= 0) ? one << g : '0;
      ea    = (g >= 0) ? req_operand_a[32*g +: 32] : '0;
      eb    = (g >= 0) ? req_operand_b[32*g +: 32] : '0;
      es    = (g >= 0) ? req_select_op[4*g +: 4] : '0;
      e_rv  = m_busy ? one << m_owner : '0;
      e_gc  = '0;
`ifdef ALU_ARB_STATS_EN
      for (int i = 0; i < N; i++) e_gc[16*i +: 16] = 16'(m_cnt[i]);
`endif
      if (do_chk) begin
         chk("req_ready", 64'(req_ready), 64'(e_rdy));
         chk("resp_valid", 64'(resp_valid), 64'(e_rv));
         chk("resp_data", 64'(resp_data), 64'(m_data));
         chk("alu_a", 64'(alu_operand_a), 64'(ea));
         chk("alu_b", 64'(alu_operand_b), 64'(eb));
         chk("alu_sel", 64'(alu_select_op), 64'(es));
         chk("grant_count", 64'(grant_count), 64'(e_gc));
      end
      @(posedge clk);
      if (g >= 0) pend[g] = 1'b0;
      if (rst) begin
         m_busy  = 1'b0;
         m_owner = 0;
         m_last  = N - 1;
         m_data  = '0;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else if (g >= 0) begin
         m_data  = ref_alu(ea, eb, es);
         m_owner = g;
         m_last  = g;
         m_busy  = 1'b1;
         if (m_cnt[g] < 65535) m_cnt[g]++;
      end else if (m_busy && bit_at(resp_ready, m_owner)) begin
         m_busy = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      rst           = 1'b1;
      req_valid     = '0;
      resp_ready    = '0;
      req_operand_a = '0;
      req_operand_b = '0;
      req_select_op = '0;
      pend          = '0;
      cycle(0);
      cycle(0);
      rst = 1'b0;

      // Idle after reset.
      #1;
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_data", 64'(resp_data), 64'd0);
      cycle(1);

      // Single unsigned add from requester 0.
      set_req(0, 32'h5, 32'h3, 4'd0);
      req_valid  = 2'b01;
      resp_ready = 2'b01;
      cycle(1);
      req_valid = '0;
      #1;
      chk("add_valid", 64'(resp_valid), 64'h1);
      chk("add_data", 64'(resp_data), 64'h8);
      cycle(1);
      cycle(1);

      // Signed subtract with wrap from requester 1.
      set_req(1, 32'h2, 32'h5, 4'd3);
      req_valid  = 2'b10;
      resp_ready = 2'b10;
      cycle(1);
      req_valid = '0;
      #1;
      chk("ssub_valid", 64'(resp_valid), 64'h2);
      chk("ssub_data", 64'(resp_data), 64'hFFFF_FFFD);
      cycle(1);

      // Contention: grants alternate 0,1,0,1.
      set_req(0, 32'h1111_0000, 32'h0000_2222, 4'd0);
      set_req(1, 32'h8000_0000, 32'h0000_0001, 4'd1);
      req_valid  = 2'b11;
      resp_ready = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_grant", 64'(req_ready), (k % 2 == 1) ? 64'h2 : 64'h1);
         cycle(1);
      end
      req_valid = '0;
      cycle(1);

      // Response stall blocks requester 1.
      set_req(0, 32'hDEAD_0000, 32'h0000_BEEF, 4'd2);
      req_valid  = 2'b01;
      resp_ready = 2'b00;
      cycle(1);
      set_req(1, 32'h10, 32'h20, 4'd9);
      req_valid = 2'b10;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_rdy", 64'(req_ready), 64'h0);
         chk("stall_data", 64'(resp_data), 64'hDEAD_BEEF);
         cycle(1);
      end
      resp_ready = 2'b01;
      #1;
      chk("unstall_rdy", 64'(req_ready), 64'h2);
      cycle(1);
      req_valid = '0;
      #1;
      chk("unstall_valid", 64'(resp_valid), 64'h2);
      chk("unstall_data", 64'(resp_data), 64'h30);
      resp_ready = 2'b11;
      cycle(1);

      // Reset while a response is held.
      set_req(0, 32'h7, 32'h7, 4'd0);
      req_valid  = 2'b01;
      resp_ready = 2'b00;
      cycle(1);
      req_valid = '0;
      rst       = 1'b1;
      cycle(1);
      rst = 1'b0;
      #1;
      chk("midrst_valid", 64'(resp_valid), 64'h0);
      chk("midrst_count", 64'(grant_count), 64'h0);
      cycle(1);

      // Random traffic.
      pend = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 9) < 6) begin
               pend[i] = 1'b1;
               set_req(i,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom),
                  ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15))
                                              : 4'($urandom_range(0, 3)));
            end
            req_valid[i]  = pend[i];
            resp_ready[i] = ($urandom_range(0, 3) != 0);
         end
         rst = ($urandom_range(0, 199) == 0);
         cycle(1);
      end
      rst       = 1'b0;
      req_valid = '0;
      cycle(1);

`ifdef ALU_ARB_STATS_EN
      // Counter saturation.
      rst = 1'b1;
      cycle(1);
      rst = 1'b0;
      set_req(0, 32'h1, 32'h1, 4'd0);
      req_valid  = 2'b01;
      resp_ready = 2'b11;
      for (int k = 0; k < 70000; k++) cycle(k % 64 == 0);
      req_valid = '0;
      #1;
      chk("sat_count", 64'(grant_count), 64'h0000_FFFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (add/sub, unsigned and signed) between NUM_REQ requesters, e.g. the integer datapath and an address-generation or debug port.
- Each request carries two 32-bit operands and a 4-bit ALU select. The block grants requesters in round-robin order and drives the ALU with the granted request.
- The ALU result is registered and returned over a valid/ready response channel.
- Sustained throughput is one operation per cycle when responses are consumed immediately.

Parameters:
NUM_REQ, 2, number of requesters (legal 2..4)
PTR_W, 2, width of grant/owner index (must satisfy 2**PTR_W >= NUM_REQ)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept strobe (one-hot or zero)
req_operand_a  input  NUM_REQ*32  packed operand A; requester i in bits [32i+31:32i]
req_operand_b  input  NUM_REQ*32  packed operand B; same packing
req_select_op  input  NUM_REQ*4  packed ALU select; requester i in bits [4i+3:4i]
resp_valid  output  NUM_REQ  one-hot response valid for the owning requester
resp_ready  input  NUM_REQ  per-requester response accept
resp_data  output  32  registered ALU result, shared by all requesters
alu_operand_a  output  32  to ALU operand_a
alu_operand_b  output  32  to ALU operand_b
alu_select_op  output  4  to ALU select_op
alu_result_in  input  32  from ALU result_out (combinational)
grant_count  output  NUM_REQ*16  per-requester accepted-request counters (see Optional Feature)

Behaviour:
Reset (rst high at a clk edge):
- state=IDLE, resp_valid=0, resp_data=0, owner=0.
- last_grant=NUM_REQ-1, so requester 0 has first priority.
- grant_count=0.
- Reset mid-operation discards any held response; resp_valid is 0 from the next cycle.

State machine, two states:
- IDLE: no response held.
- RESP: resp_data holds the result for requester owner, and resp_valid[owner]=1.

Accept condition (combinational):
- can_accept = (state==IDLE) || (state==RESP && resp_ready[owner]).
- When can_accept and any req_valid bit is set, grant g is chosen round-robin: first valid index searching from last_grant+1 upward, wrapping modulo NUM_REQ.
- req_ready[g]=1 and all other req_ready bits are 0. If the accept condition is not met, req_ready=0.

ALU drive:
- During a grant, alu_operand_a/b/select_op equal the granted requester's fields.
- Otherwise the ALU is driven with 0/0/4'b0000.
- select_op passes through unmodified. Codes 0000 (add), 0001 (sub), 0010 (signed add) and 0011 (signed sub) are defined; any other code yields the ALU default (add).

On a clock edge with an accept:
- resp_data <= alu_result_in, owner <= g, last_grant <= g, state <= RESP.

On a clock edge with resp_ready[owner] in RESP and no new accept:
- state <= IDLE and resp_valid drops.
- resp_data keeps its value.

Timing:
- Latency: request accepted in cycle N, so resp_valid is asserted in cycle N+1.
- A back-to-back accept in the same cycle as a response handshake keeps state=RESP with the new owner and new data.

Handshake rules:
- Requesters hold req_valid and their operands stable until req_ready.
- The block never drops resp_valid without resp_ready[owner].
- resp_ready bits of non-owners are ignored.
- While in RESP without resp_ready[owner], no request is accepted: req_ready=0 and the ALU drive is zero.

Arithmetic: 32-bit, wrap-around, no carry or overflow outputs. Results equal the ALU's results bit-for-bit.

Optional Feature:
Macro: ALU_ARB_STATS_EN
- Defined: grant_count[16i+15:16i] increments on every accept of requester i and saturates at 16'hFFFF. It is cleared by rst.
- Not defined: grant_count is tied to 0 and no counter flops exist. The port is present in both builds.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all req_valid=0 -> resp_valid=0, req_ready=0, resp_data=0, ALU drive 0/0/0.
- Single add: req0 valid, a=32'h0000_0005, b=32'h0000_0003, sel=0000, resp_ready0=1 -> req_ready=01 in cycle N; resp_valid=01 and resp_data=32'h0000_0008 in N+1; IDLE in N+2.
- Signed subtract wrap: req1 a=32'h0000_0002, b=32'h0000_0005, sel=0011 -> resp_data=32'hFFFF_FFFD, resp_valid=10.
- Round-robin contention: both requesters valid continuously, resp_ready=11 -> grants alternate 0,1,0,1 with one result per cycle; each resp_data matches its requester's operands.
- Response stall: resp_ready0=0 for 3 cycles while req1 is valid -> resp_valid=01 and resp_data held constant, req_ready=00. When resp_ready0=1, req1 is granted in the same cycle and resp_valid=10 the next cycle.
- Reset mid-response plus stats (ALU_ARB_STATS_EN defined):
  - Hold a response, assert rst for one cycle -> resp_valid=0 and grant_count=0 next cycle.
  - Then 70000 accepts by req0 -> grant_count[15:0]=16'hFFFF (saturated), grant_count[31:16]=0.
